// File: rtl/sram_pkg.sv
// Shared types and elaboration-time helpers for the masked single-port SRAM model.
package sram_pkg;

    typedef enum logic [0:0] {
        ST_INIT,
        ST_IDLE
    } sram_state_e;

    function automatic int unsigned group_width(input int unsigned data_w,
                                                input int unsigned mask_w);
        return data_w / mask_w;
    endfunction

    function automatic bit read_lat_ok(input int unsigned lat);
        return (lat == 1) || (lat == 2);
    endfunction

    function automatic bit params_ok(input int unsigned depth, input int unsigned addr_w,
                                     input int unsigned data_w, input int unsigned mask_w,
                                     input int unsigned read_lat);
        return (mask_w != 0) && ((data_w % mask_w) == 0) && read_lat_ok(read_lat) &&
               (depth >= 2) && (depth == (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/sram_init_seq.sv
// Post-reset zeroing sweep: walks every address once, then raises ready for good.
module sram_init_seq
    import sram_pkg::*;
#(
    parameter int unsigned Depth       = 256,
    parameter int unsigned AddrW       = 8,
    parameter bit          InitOnReset = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic             init_we_o,
    output logic [AddrW-1:0] init_addr_o,
    output logic             ready_o
);

    localparam logic [AddrW-1:0] LastAddr = AddrW'(Depth - 1);

    sram_state_e      state_q, state_d;
    logic [AddrW-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastAddr) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: ready_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= InitOnReset ? ST_INIT : ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign init_we_o   = (state_q == ST_INIT);
    assign init_addr_o = cnt_q;
    assign ready_o     = ready_q;

endmodule

// File: rtl/sram_sp_masked_init.sv
// Single-port synchronous-read SRAM with group write mask, zeroing sweep and 1/2-cycle reads.
module sram_sp_masked_init
    import sram_pkg::*;
#(
    parameter int unsigned DEPTH         = 256,
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned DATA_W        = 20,
    parameter int unsigned MASK_W        = 10,
    parameter int unsigned READ_LAT      = 1,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic              RW0_clk,
    input  logic              RW0_rst_n,
    input  logic [ADDR_W-1:0] RW0_addr,
    input  logic              RW0_en,
    input  logic              RW0_wmode,
    input  logic [MASK_W-1:0] RW0_wmask,
    input  logic [DATA_W-1:0] RW0_wdata,
    output logic              RW0_ready,
    output logic              RW0_rvalid,
    output logic [DATA_W-1:0] RW0_rdata
);

    localparam int unsigned G = group_width(DATA_W, MASK_W);

    if (!params_ok(DEPTH, ADDR_W, DATA_W, MASK_W, READ_LAT)) begin : g_bad_params
        $error("sram_sp_masked_init: illegal DEPTH/ADDR_W/DATA_W/MASK_W/READ_LAT");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic              ready;

    sram_init_seq #(
        .Depth       (DEPTH),
        .AddrW       (ADDR_W),
        .InitOnReset (INIT_ON_RESET)
    ) u_init_seq (
        .clk_i       (RW0_clk),
        .rst_ni      (RW0_rst_n),
        .init_we_o   (init_we),
        .init_addr_o (init_addr),
        .ready_o     (ready)
    );

    // Nothing touches the array on a reset edge, including the sweep itself.
    logic req_ok, rd_en, wr_en;
    assign req_ok = RW0_rst_n && ready && RW0_en;
    assign rd_en  = req_ok && !RW0_wmode;
    assign wr_en  = RW0_rst_n && (init_we || (req_ok && RW0_wmode));

    logic [DATA_W-1:0] bit_mask, wr_word, rd_word;
    logic [ADDR_W-1:0] wr_addr;

    always_comb begin
        bit_mask = '0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            bit_mask[i*G +: G] = {G{RW0_wmask[i]}};
        end
        if (init_we) begin
            wr_addr = init_addr;
            wr_word = '0;
        end else begin
            wr_addr = RW0_addr;
            wr_word = (mem_q[RW0_addr] & ~bit_mask) | (RW0_wdata & bit_mask);
        end
    end

    always_ff @(posedge RW0_clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_word;
        end
    end

    assign rd_word = mem_q[RW0_addr];

    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    if (READ_LAT == 2) begin : g_lat2
        logic              s1_valid_q;
        logic [DATA_W-1:0] s1_data_q, s1_data_d;

        always_comb begin
            s1_data_d = rd_en ? rd_word : s1_data_q;
            rvalid_d  = s1_valid_q;
            rdata_d   = s1_valid_q ? s1_data_q : rdata_q;
        end

        always_ff @(posedge RW0_clk) begin
            if (!RW0_rst_n) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
            end else begin
                s1_valid_q <= rd_en;
                s1_data_q  <= s1_data_d;
            end
        end
    end else begin : g_lat1
        always_comb begin
            rvalid_d = rd_en;
            rdata_d  = rd_en ? rd_word : rdata_q;
        end
    end

    always_ff @(posedge RW0_clk) begin
        if (!RW0_rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign RW0_ready  = ready;
    assign RW0_rvalid = rvalid_q;
    assign RW0_rdata  = rdata_q;

endmodule

// File: tb/tb_sram_sp_masked_init.sv
// Bench: two default-geometry instances (latency 1 and 2) against an array model,
// plus a 64x64 byte-masked instance without the init sweep.
module tb_sram_sp_masked_init;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the two 256x20 instances.
    logic        rst_n = 1'b0;
    logic [7:0]  addr = '0;
    logic        en = 1'b0, wmode = 1'b0;
    logic [9:0]  wmask = '0;
    logic [19:0] wdata = '0;
    logic        ready_a, rvalid_a, ready_b, rvalid_b;
    logic [19:0] rdata_a, rdata_b;

    // Stimulus for the 64x64 instance.
    logic        c_rst_n = 1'b0;
    logic [5:0]  c_addr = '0;
    logic        c_en = 1'b0, c_wmode = 1'b0;
    logic [7:0]  c_wmask = '0;
    logic [63:0] c_wdata = '0;
    logic        ready_c, rvalid_c;
    logic [63:0] rdata_c;

    sram_sp_masked_init #(.READ_LAT(1)) dut_a (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr), .RW0_en(en),
        .RW0_wmode(wmode), .RW0_wmask(wmask), .RW0_wdata(wdata),
        .RW0_ready(ready_a), .RW0_rvalid(rvalid_a), .RW0_rdata(rdata_a)
    );

    sram_sp_masked_init #(.READ_LAT(2)) dut_b (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr), .RW0_en(en),
        .RW0_wmode(wmode), .RW0_wmask(wmask), .RW0_wdata(wdata),
        .RW0_ready(ready_b), .RW0_rvalid(rvalid_b), .RW0_rdata(rdata_b)
    );

    sram_sp_masked_init #(
        .DEPTH(64), .ADDR_W(6), .DATA_W(64), .MASK_W(8), .READ_LAT(1), .INIT_ON_RESET(1'b0)
    ) dut_c (
        .RW0_clk(clk), .RW0_rst_n(c_rst_n), .RW0_addr(c_addr), .RW0_en(c_en),
        .RW0_wmode(c_wmode), .RW0_wmask(c_wmask), .RW0_wdata(c_wdata),
        .RW0_ready(ready_c), .RW0_rvalid(rvalid_c), .RW0_rdata(rdata_c)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model of the 256x20 instances ----------------
    typedef struct {
        int          due;
        logic [19:0] d;
    } rd_t;

    bit          started = 1'b0;
    int          since = 0;
    int          ecnt = 0;
    logic [19:0] mm [256];
    rd_t         qa[$];
    rd_t         qb[$];
    logic        exp_ready = 1'b0, exp_va = 1'b0, exp_vb = 1'b0;
    logic [19:0] exp_da = '0, exp_db = '0;

    always @(posedge clk) begin
        ecnt++;
        if (!rst_n) begin
            started   = 1'b1;
            since     = 0;
            exp_ready = 1'b0;
            qa.delete();
            qb.delete();
            exp_va = 1'b0;
            exp_vb = 1'b0;
            exp_da = '0;
            exp_db = '0;
        end else begin
            if (exp_ready && en) begin
                if (wmode) begin
                    for (int g = 0; g < 10; g++)
                        if (wmask[g]) mm[addr][2*g +: 2] = wdata[2*g +: 2];
                end else begin
                    qa.push_back('{ecnt, mm[addr]});
                    qb.push_back('{ecnt + 1, mm[addr]});
                end
            end
            since++;
            // A completed sweep leaves every entry zero.
            if (since == 256) begin
                for (int i = 0; i < 256; i++) mm[i] = '0;
            end
            exp_ready = (since >= 256);
            exp_va = 1'b0;
            if (qa.size() > 0 && qa[0].due == ecnt) begin
                exp_va = 1'b1;
                exp_da = qa[0].d;
                void'(qa.pop_front());
            end
            exp_vb = 1'b0;
            if (qb.size() > 0 && qb[0].due == ecnt) begin
                exp_vb = 1'b1;
                exp_db = qb[0].d;
                void'(qb.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_ready_a", ready_a, exp_ready);
            chk("model_rvalid_a", rvalid_a, exp_va);
            chk("model_rdata_a", rdata_a, exp_da);
            chk("model_ready_b", ready_b, exp_ready);
            chk("model_rvalid_b", rvalid_b, exp_vb);
            chk("model_rdata_b", rdata_b, exp_db);
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [19:0] d, input logic [9:0] m);
        en = 1'b1; wmode = 1'b1; addr = a; wdata = d; wmask = m;
        tick();
        en = 1'b0;
    endtask

    task automatic rd_check(input logic [7:0] a, input logic [19:0] e, input string nm);
        en = 1'b1; wmode = 1'b0; addr = a;
        tick();
        en = 1'b0;
        chk({nm, "_rvalid_a"}, rvalid_a, 1'b1);
        chk({nm, "_rdata_a"}, rdata_a, e);
        tick();
        chk({nm, "_rvalid_b"}, rvalid_b, 1'b1);
        chk({nm, "_rdata_b"}, rdata_b, e);
    endtask

    // Count cycles from reset release until ready; optionally poke a write mid-sweep.
    task automatic wait_ready(input bit poke, output int n);
        n = 0;
        while (!ready_a && n < 400) begin
            if (poke && n == 9) begin
                en = 1'b1; wmode = 1'b1; addr = 8'h05; wdata = 20'hABCDE; wmask = 10'h3FF;
            end else begin
                en = 1'b0;
            end
            tick();
            n++;
        end
        en = 1'b0;
    endtask

    initial begin
        int n;

        // Reset held for 3 cycles, then the sweep.
        repeat (3) tick();
        chk("rst_ready_a", ready_a, 1'b0);
        chk("rst_rvalid_b", rvalid_b, 1'b0);
        chk("rst_rdata_a", rdata_a, 20'h0);
        rst_n = 1'b1;
        wait_ready(1'b1, n);
        chk("init_cycles", n, 256);
        chk("init_ready_b", ready_b, 1'b1);
        rd_check(8'h00, 20'h00000, "init_rd_00");
        rd_check(8'h7F, 20'h00000, "init_rd_7f");
        rd_check(8'hFF, 20'h00000, "init_rd_ff");
        rd_check(8'h05, 20'h00000, "init_write_ignored");

        // Masked write: clear only group 0.
        wr(8'h10, 20'hFFFFF, 10'h3FF);
        wr(8'h10, 20'h00000, 10'h001);
        chk("write_no_rvalid", rvalid_a, 1'b0);
        rd_check(8'h10, 20'hFFFFC, "mask_rd");
        wr(8'h10, 20'h12345, 10'h000);
        rd_check(8'h10, 20'hFFFFC, "mask_zero_noop");

        // Back-to-back reads through the 2-cycle instance.
        wr(8'h01, 20'h11111, 10'h3FF);
        wr(8'h02, 20'h22222, 10'h3FF);
        wr(8'h03, 20'h33333, 10'h3FF);
        en = 1'b1; wmode = 1'b0; addr = 8'h01;
        tick();
        chk("lat2_n1_rvalid", rvalid_b, 1'b0);
        addr = 8'h02;
        tick();
        chk("lat2_n2_rvalid", rvalid_b, 1'b1);
        chk("lat2_n2_rdata", rdata_b, 20'h11111);
        addr = 8'h03;
        tick();
        chk("lat2_n3_rdata", rdata_b, 20'h22222);
        en = 1'b0;
        tick();
        chk("lat2_n4_rvalid", rvalid_b, 1'b1);
        chk("lat2_n4_rdata", rdata_b, 20'h33333);
        tick();
        chk("hold_rvalid", rvalid_b, 1'b0);
        chk("hold_rdata", rdata_b, 20'h33333);
        repeat (3) tick();
        chk("hold_rdata_later", rdata_b, 20'h33333);

        // Random traffic over a small address window to force hits.
        for (int i = 0; i < 400; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            wmode = $urandom_range(0, 1);
            addr  = 8'($urandom_range(0, 15));
            wdata = 20'($urandom);
            wmask = 10'($urandom);
            tick();
        end
        en = 1'b0;
        tick();

        // Read-after-write on consecutive cycles.
        wr(8'h20, 20'h5A5A5, 10'h3FF);
        rd_check(8'h20, 20'h5A5A5, "raw_rd");

        // Reset one cycle after a read issues: the read never completes.
        en = 1'b1; wmode = 1'b0; addr = 8'h02;
        tick();
        en = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("midrd_rvalid_b", rvalid_b, 1'b0);
        chk("midrd_rdata_b", rdata_b, 20'h0);
        chk("midrd_ready", ready_a, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("midrd_rvalid_b_after", rvalid_b, 1'b0);
        wait_ready(1'b0, n);
        chk("reinit_cycles", n + 1, 256);
        rd_check(8'h02, 20'h00000, "reinit_rd_02");

        // No-sweep 64-bit instance with byte mask.
        c_rst_n = 1'b0;
        repeat (2) tick();
        chk("c_rst_ready", ready_c, 1'b0);
        chk("c_rst_rdata", rdata_c, 64'h0);
        c_rst_n = 1'b1;
        tick();
        chk("c_ready_next", ready_c, 1'b1);
        c_en = 1'b1; c_wmode = 1'b1; c_addr = 6'd3;
        c_wdata = 64'h0123_4567_89AB_CDEF; c_wmask = 8'hFF;
        tick();
        c_wdata = 64'hA5FF_FFFF_FFFF_FFFF; c_wmask = 8'h80;
        tick();
        chk("c_write_no_rvalid", rvalid_c, 1'b0);
        c_wmode = 1'b0;
        tick();
        c_en = 1'b0;
        chk("c_rvalid", rvalid_c, 1'b1);
        chk("c_bytemask_rdata", rdata_c, 64'hA523_4567_89AB_CDEF);
        tick();
        chk("c_hold_rvalid", rvalid_c, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
